// File: rtl/jk_bank_sequencer.sv
// -----------------------------------------------------------------------------
// jk_bank_sequencer
//
// Purpose:
//   Command-driven controller for a bank of N JK flip-flops. Commands
//   (hold / reset / set / toggle, single bit or broadcast) are buffered in a
//   small FIFO and issued one at a time. Each issue drives J/K for exactly
//   one cycle, waits SETTLE_CYC cycles, and then pulses done. The
//   architectural Q state of the bank is kept here and exported on q_out.
//
// Handshake:
//   A command is accepted on a rising edge where cmd_valid && cmd_ready.
//   cmd_ready is simply !fifo_full. It does not look ahead at a pop in the
//   same cycle, so a full FIFO refuses the push even while it is being
//   drained. The producer holds cmd_* stable while cmd_valid is high and
//   cmd_ready is low.
//
// Parameters:
//   N           number of flip-flops (2..32)
//   AW          bit-address width (default $clog2(N), min 1). It may be
//               widened so that out-of-range addresses can be presented.
//   FIFO_DEPTH  command FIFO entries, power of two, 2..16
//   SETTLE_CYC  idle cycles after each issue before done, 0..15
//
// Ports:
//   clk          rising-edge clock
//   r            asynchronous active-low reset
//   cmd_valid    command present
//   cmd_ready    FIFO can accept (== !fifo_full)
//   cmd_op       00 hold, 01 reset (K), 10 set (J), 11 toggle (J&K)
//   cmd_addr     target bit index
//   cmd_bcast    apply op to all N bits; cmd_addr ignored
//   j_out/k_out  J/K drive to the bank; nonzero only in the ISSUE cycle
//   q_out        current bank state
//   busy         FSM not in IDLE
//   done         one-cycle pulse per completed command
//   err          one-cycle pulse (in ISSUE) for an out-of-range address
//   fifo_empty   FIFO empty
//   fifo_full    FIFO full
//   toggle_cnt   (only with JKBANK_TOGGLE_COUNT_EN) saturating count of
//                valid toggle issues
//   o_dbg_state  current FSM state, for observation
//
// Optional feature macro: JKBANK_TOGGLE_COUNT_EN
// -----------------------------------------------------------------------------
module jk_bank_sequencer #(
    parameter int N          = 8,
    parameter int AW         = (N < 2) ? 1 : $clog2(N),
    parameter int FIFO_DEPTH = 4,
    parameter int SETTLE_CYC = 2
) (
    input  logic          clk,
    input  logic          r,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [1:0]    cmd_op,
    input  logic [AW-1:0] cmd_addr,
    input  logic          cmd_bcast,
    output logic [N-1:0]  j_out,
    output logic [N-1:0]  k_out,
    output logic [N-1:0]  q_out,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic          fifo_empty,
    output logic          fifo_full,
`ifdef JKBANK_TOGGLE_COUNT_EN
    output logic [15:0]   toggle_cnt,
`endif
    output logic [1:0]    o_dbg_state
);

    localparam int PW = (FIFO_DEPTH < 2) ? 1 : $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = AW + 3;
    localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
    localparam logic [3:0]    SETTLE_LD = 4'(SETTLE_CYC);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_SETTLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // FIFO storage: entry = {op[1:0], addr[AW-1:0], bcast}
    logic [EW-1:0] r_mem [FIFO_DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    state_t        r_state;
    state_t        w_next_state;

    // Command currently being executed, latched at the pop edge
    logic [1:0]    r_op;
    logic [AW-1:0] r_addr;
    logic          r_bcast;

    logic [3:0]    r_settle;
    logic [N-1:0]  r_q;

    logic          w_push;
    logic          w_pop;
    logic          w_addr_ok;
    logic [N-1:0]  w_mask;
    logic [N-1:0]  w_j;
    logic [N-1:0]  w_k;
    logic          w_err;
    logic [EW-1:0] w_head;

    // ---------------------------------------------------------------- FIFO
    assign fifo_empty = (r_count == '0);
    assign fifo_full  = (r_count == DEPTH_C);
    assign cmd_ready  = !fifo_full;
    assign w_push     = cmd_valid && !fifo_full;
    assign w_head     = r_mem[r_rd_ptr];

    // Storage needs no reset: r_count guards every read.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {cmd_op, cmd_addr, cmd_bcast};
        end
    end

    // Pointers wrap naturally because FIFO_DEPTH is a power of two;
    // r_count tells full from empty.
    always_ff @(posedge clk or negedge r) begin
        if (!r) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or negedge r) begin
        if (!r) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_pop        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    w_pop        = 1'b1;
                    w_next_state = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                w_next_state = (SETTLE_CYC > 0) ? ST_SETTLE : ST_DONE;
            end
            ST_SETTLE: begin
                // Counter was loaded with SETTLE_CYC on entry, so SETTLE
                // lasts exactly SETTLE_CYC cycles.
                if (r_settle <= 4'd1) w_next_state = ST_DONE;
            end
            ST_DONE: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Latch the popped command for the duration of its execution
    always_ff @(posedge clk or negedge r) begin
        if (!r) begin
            r_op    <= 2'b00;
            r_addr  <= '0;
            r_bcast <= 1'b0;
        end else if (w_pop) begin
            r_op    <= w_head[EW-1:EW-2];
            r_addr  <= w_head[AW:1];
            r_bcast <= w_head[0];
        end
    end

    always_ff @(posedge clk or negedge r) begin
        if (!r) begin
            r_settle <= 4'd0;
        end else if (r_state == ST_ISSUE) begin
            r_settle <= SETTLE_LD;
        end else if (r_state == ST_SETTLE && r_settle != 4'd0) begin
            r_settle <= r_settle - 4'd1;
        end
    end

    // ---------------------------------------------------------------- J/K
    always_comb begin
        w_addr_ok = r_bcast || (32'(r_addr) < 32'(N));
        w_mask    = '0;
        for (int i = 0; i < N; i++) begin
            w_mask[i] = r_bcast || (r_addr == AW'(i));
        end
        w_j   = '0;
        w_k   = '0;
        w_err = 1'b0;
        if (r_state == ST_ISSUE) begin
            if (w_addr_ok) begin
                w_j = r_op[1] ? w_mask : '0;
                w_k = r_op[0] ? w_mask : '0;
            end else begin
                w_err = 1'b1;
            end
        end
    end

    // JK characteristic equation; untargeted bits see J=K=0 and hold.
    always_ff @(posedge clk or negedge r) begin
        if (!r) begin
            r_q <= '0;
        end else if (r_state == ST_ISSUE) begin
            r_q <= (w_j & ~r_q) | (~w_k & r_q);
        end
    end

`ifdef JKBANK_TOGGLE_COUNT_EN
    logic [15:0] r_toggle_cnt;

    always_ff @(posedge clk or negedge r) begin
        if (!r) begin
            r_toggle_cnt <= 16'd0;
        end else if (r_state == ST_ISSUE && w_addr_ok && r_op == 2'b11
                     && r_toggle_cnt != 16'hFFFF) begin
            r_toggle_cnt <= r_toggle_cnt + 16'd1;
        end
    end

    assign toggle_cnt = r_toggle_cnt;
`endif

    // ---------------------------------------------------------------- outputs
    assign j_out       = w_j;
    assign k_out       = w_k;
    assign err         = w_err;
    assign q_out       = r_q;
    assign busy        = (r_state != ST_IDLE);
    assign done        = (r_state == ST_DONE);
    assign o_dbg_state = r_state;

endmodule
